// File: rtl/block_stream_emitter_if.sv
// Command-in / character-out handshake bundle for block_stream_emitter.
// The emitter takes the master side; the command source and character sink take the slave side.
interface block_stream_emitter_if #(
  parameter int unsigned DEPTH_W = 8
);
  logic               cmd_valid;
  logic [1:0]         cmd;
  logic [7:0]         cmd_char;
  logic               cmd_ready;
  logic               out_valid;
  logic [7:0]         out_char;
  logic               out_ready;
  logic [DEPTH_W-1:0] depth;
  logic               balanced;
  logic               err_under;
  logic               err_over;

  modport master (
    input  cmd_valid, cmd, cmd_char, out_ready,
    output cmd_ready, out_valid, out_char, depth, balanced, err_under, err_over
  );

  modport slave (
    output cmd_valid, cmd, cmd_char, out_ready,
    input  cmd_ready, out_valid, out_char, depth, balanced, err_under, err_over
  );
endinterface

// File: rtl/block_stream_emitter.sv
// Turns BEGIN/END/WORD/CLOSE_ALL commands into a space-prefixed character stream.
// It tracks nesting depth and raises sticky under/overflow flags.
module block_stream_emitter #(
  parameter int unsigned DEPTH_W = 8,
  parameter bit          UPPER   = 1'b0
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  block_stream_emitter_if.master bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StEmit  = 2'd1;
  localparam logic [1:0] StClose = 2'd2;

  // Token kinds reuse the command encoding.
  localparam logic [1:0] TokBegin = 2'b00;
  localparam logic [1:0] TokEnd   = 2'b01;
  localparam logic [1:0] TokWord  = 2'b10;
  localparam logic [1:0] CmdClose = 2'b11;

  localparam logic [DEPTH_W-1:0] DepthOne = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] DepthMax = '1;

  logic [1:0]         state_q, state_d;
  logic [1:0]         kind_q, kind_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         wch_q, wch_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               under_q, under_d;
  logic               over_q, over_d;
  logic               cmd_ready;
  logic               accept;
  logic               last;

  function automatic logic [7:0] tok_char(logic [1:0] kind, logic [2:0] idx, logic [7:0] wch);
    logic [7:0] c;
    c = 8'h20;
    unique case (kind)
      TokBegin: begin
        unique case (idx)
          3'd1:    c = 8'h62;
          3'd2:    c = 8'h65;
          3'd3:    c = 8'h67;
          3'd4:    c = 8'h69;
          3'd5:    c = 8'h6e;
          default: c = 8'h20;
        endcase
      end
      TokEnd: begin
        unique case (idx)
          3'd1:    c = 8'h65;
          3'd2:    c = 8'h6e;
          3'd3:    c = 8'h64;
          default: c = 8'h20;
        endcase
      end
      default: c = (idx == 3'd0) ? 8'h20 : wch;
    endcase
    // Only keyword letters fold to uppercase; the space and WORD payload pass through.
    if (UPPER && kind != TokWord && idx != 3'd0) c = c & 8'hdf;
    return c;
  endfunction

  always_comb begin
    unique case (kind_q)
      TokBegin: last = (idx_q == 3'd5);
      TokEnd:   last = (idx_q == 3'd3);
      default:  last = (idx_q == 3'd1);
    endcase
  end

  // Held low for the whole reset window, not just until the flops settle.
  assign cmd_ready = rst_ni && (state_q == StIdle);
  assign accept    = bus.cmd_valid && cmd_ready;

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    idx_d   = idx_q;
    wch_d   = wch_q;
    depth_d = depth_q;
    under_d = under_q;
    over_d  = over_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          idx_d = 3'd0;
          if (bus.cmd == CmdClose) begin
            kind_d = TokEnd;
            if (depth_q != '0) state_d = StClose;
          end else begin
            kind_d  = bus.cmd;
            wch_d   = bus.cmd_char;
            state_d = StEmit;
            if (bus.cmd == TokBegin) begin
              if (depth_q == DepthMax) over_d = 1'b1;
              else depth_d = depth_q + DepthOne;
            end else if (bus.cmd == TokEnd) begin
              if (depth_q == '0) under_d = 1'b1;
              else depth_d = depth_q - DepthOne;
            end
          end
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (last) state_d = StIdle;
          else idx_d = idx_q + 3'd1;
        end
      end
      StClose: begin
        if (bus.out_ready) begin
          if (last) begin
            depth_d = depth_q - DepthOne;
            idx_d   = 3'd0;
            if (depth_q == DepthOne) state_d = StIdle;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      kind_q  <= TokWord;
      idx_q   <= 3'd0;
      wch_q   <= 8'h20;
      depth_q <= '0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      idx_q   <= idx_d;
      wch_q   <= wch_d;
      depth_q <= depth_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.out_valid = (state_q != StIdle);
  assign bus.out_char  = tok_char(kind_q, idx_q, wch_q);
  assign bus.depth     = depth_q;
  assign bus.err_under = under_q;
  assign bus.err_over  = over_q;
  assign bus.balanced  = (depth_q == '0) && !under_q && !over_q;

endmodule
